// File: rtl/fib_pkg.sv
// Shared types and default widths for the fib engine and its dispatcher.
package fib_pkg;

    localparam int unsigned FIB_N_W   = 4;
    localparam int unsigned FIB_F_W   = 10;
    localparam int unsigned FIB_TAG_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT
    } fib_state_t;

    typedef struct packed {
        logic [FIB_N_W-1:0]   n;
        logic [FIB_TAG_W-1:0] tag;
    } fib_req_t;

endpackage

// File: rtl/fib_req_fifo.sv
// Request FIFO: power-of-two depth, registered occupancy count, no bypass.
module fib_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fib_dispatch.sv
// Queues Fibonacci requests, issues them one at a time to the fib engine and
// returns each result with its index and tag on a valid/ready port.
module fib_dispatch
    import fib_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = FIB_TAG_W,
    parameter int unsigned N_W   = FIB_N_W,
    parameter int unsigned F_W   = FIB_F_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N_W-1:0]   req_n,
    input  logic [TAG_W-1:0] req_tag,
    output logic             fib_start,
    output logic [N_W-1:0]   fib_n,
    input  logic             fib_busy,
    input  logic             fib_done,
    input  logic [F_W-1:0]   fib_f,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [F_W-1:0]   res_f,
    output logic [N_W-1:0]   res_n,
    output logic [TAG_W-1:0] res_tag
);

    localparam int unsigned REQ_W = N_W + TAG_W;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    fib_state_t       state;
    logic [N_W-1:0]   cur_n;
    logic [TAG_W-1:0] cur_tag;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REQ_W-1:0] fifo_dout;
    logic [CW-1:0]    fifo_count;

    assign req_ready = (fifo_count < CW'(DEPTH));
    assign fifo_push = req_valid && !fifo_full;
    // Holding off while busy also covers an engine left running across our reset.
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty && !fib_busy;
    assign fib_start = (state == ST_ISSUE) && !fib_busy;
    assign fib_n     = cur_n;

    fib_req_fifo #(
        .DEPTH (DEPTH),
        .W     (REQ_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({req_n, req_tag}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cur_n     <= '0;
            cur_tag   <= '0;
            res_valid <= 1'b0;
            res_f     <= '0;
            res_n     <= '0;
            res_tag   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        cur_n   <= fifo_dout[REQ_W-1 -: N_W];
                        cur_tag <= fifo_dout[TAG_W-1:0];
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (fib_busy) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (fib_done) begin
                        res_f     <= fib_f;
                        res_n     <= cur_n;
                        res_tag   <= cur_tag;
                        res_valid <= 1'b1;
                        state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_dispatch.sv
// Bench for fib_dispatch: behavioural fib engine, scoreboard queue, directed
// scenarios followed by randomized traffic with random back-pressure and pause.
module tb_fib_dispatch;
    import fib_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_n;
    logic [3:0] req_tag;
    logic       fib_start;
    logic [3:0] fib_n;
    logic       res_valid;
    logic       res_ready;
    logic [9:0] res_f;
    logic [3:0] res_n;
    logic [3:0] res_tag;

    logic       eng_busy  = 1'b0;
    logic       eng_done  = 1'b0;
    logic       eng_pause;
    logic [3:0] eng_cnt   = '0;
    logic [3:0] eng_n     = '0;
    logic [9:0] eng_a     = '0;
    logic [9:0] eng_b     = '0;
    logic [9:0] eng_f     = '0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic        orphan   = 1'b0;
    logic        rand_on  = 1'b0;

    typedef struct {
        fib_req_t    req;
        int unsigned f;
    } exp_t;
    exp_t     exp_q[$];
    exp_t     exp_e;
    fib_req_t exp_r;

    always #5 clk = ~clk;

    fib_dispatch #(
        .DEPTH (4),
        .TAG_W (4),
        .N_W   (4),
        .F_W   (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_n     (req_n),
        .req_tag   (req_tag),
        .fib_start (fib_start),
        .fib_n     (fib_n),
        .fib_busy  (eng_busy),
        .fib_done  (eng_done),
        .fib_f     (eng_f),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_f     (res_f),
        .res_n     (res_n),
        .res_tag   (res_tag)
    );

    function automatic int unsigned fib_ref(input int unsigned n);
        int unsigned a = 1;
        int unsigned b = 1;
        int unsigned t;
        for (int unsigned i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Engine model: no reset, accepts start when idle and unpaused, pauses freeze it.
    always @(posedge clk) begin
        eng_done <= 1'b0;
        if (!eng_busy) begin
            if (fib_start && !eng_pause) begin
                eng_busy <= 1'b1;
                eng_cnt  <= fib_n;
                eng_n    <= fib_n;
                eng_a    <= 10'd1;
                eng_b    <= 10'd1;
            end
        end else if (!eng_pause) begin
            if (eng_cnt == 0) begin
                eng_busy <= 1'b0;
                eng_done <= 1'b1;
                eng_f    <= eng_a;
            end else begin
                eng_cnt <= eng_cnt - 1'b1;
                eng_a   <= eng_b;
                eng_b   <= eng_a + eng_b;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (res_valid && res_ready) begin
                check("res_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    check("res_f", 32'(res_f), exp_e.f);
                    check("res_n", 32'(res_n), 32'(exp_e.req.n));
                    check("res_tag", 32'(res_tag), 32'(exp_e.req.tag));
                end
            end
            if (req_valid && req_ready) begin
                exp_r.n   = req_n;
                exp_r.tag = req_tag;
                exp_e.req = exp_r;
                exp_e.f   = fib_ref(32'(req_n));
                exp_q.push_back(exp_e);
            end
            if (eng_busy) begin
                check("start_while_busy", 32'(fib_start), 0);
                if (!orphan) begin
                    check("fib_n_stable", 32'(fib_n), 32'(eng_n));
                end
            end
        end
    end

    task automatic push_req(input int unsigned n, input int unsigned tag);
        req_n     = 4'(n);
        req_tag   = 4'(tag);
        req_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                req_valid = 1'b0;
                return;
            end
        end
        check("push_timeout", 32'(req_ready), 1);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !res_valid) break;
        end
        check("drain", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 1);
        check({tag, "_fib_start"}, 32'(fib_start), 0);
        check({tag, "_fib_n"}, 32'(fib_n), 0);
        check({tag, "_res_valid"}, 32'(res_valid), 0);
        check({tag, "_res_f"}, 32'(res_f), 0);
        check({tag, "_res_n"}, 32'(res_n), 0);
        check({tag, "_res_tag"}, 32'(res_tag), 0);
    endtask

    initial begin
        int unsigned cyc;
        int unsigned start_cyc;
        int unsigned dir_n [5] = '{0, 1, 6, 11, 15};
        int unsigned hold_f;
        int unsigned hold_tag;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_n     = '0;
        req_tag   = '0;
        res_ready = 1'b1;
        eng_pause = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single request latency: n=5 -> 8 in cycle 10 after the push edge.
        req_n     = 4'd5;
        req_tag   = 4'd3;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc       = 1;
        start_cyc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fib_start && start_cyc == 0) start_cyc = cyc;
            if (res_valid) break;
            @(posedge clk);
            cyc++;
        end
        check("lat_start", start_cyc, 2);
        check("lat_res", cyc, 10);
        check("single_f", 32'(res_f), 8);
        check("single_n", 32'(res_n), 5);
        check("single_tag", 32'(res_tag), 3);
        wait_drain(50);

        // Back-to-back directed indices.
        for (int i = 0; i < 5; i++) push_req(dir_n[i], 32'(i + 1));
        wait_drain(300);

        // Back-pressure: one result parked in OUT, FIFO filled behind it.
        res_ready = 1'b0;
        push_req(2, 7);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        check("parked_valid", 32'(res_valid), 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) push_req(32'(i + 1), 32'(i + 8));
        req_n     = 4'd9;
        req_tag   = 4'd15;
        req_valid = 1'b1;
        hold_f    = (exp_q.size() != 0) ? exp_q[0].f : 0;
        hold_tag  = (exp_q.size() != 0) ? 32'(exp_q[0].req.tag) : 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("full_req_ready", 32'(req_ready), 0);
            check("hold_valid", 32'(res_valid), 1);
            check("hold_f", 32'(res_f), hold_f);
            check("hold_tag", 32'(res_tag), hold_tag);
            check("hold_no_start", 32'(fib_start), 0);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        res_ready = 1'b1;
        wait_drain(300);

        // Engine paused while ISSUE holds start.
        eng_pause = 1'b1;
        push_req(3, 12);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fib_start) break;
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("start_held", 32'(fib_start), 1);
        end
        @(posedge clk);
        #1;
        eng_pause = 1'b0;
        wait_drain(100);

        // Reset while the engine runs n=15; its done must be ignored.
        push_req(15, 13);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (eng_busy) break;
        end
        check("orphan_busy", 32'(eng_busy), 1);
        @(posedge clk);
        #1;
        orphan = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_req(4, 6);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!eng_busy) break;
            check("orphan_no_start", 32'(fib_start), 0);
        end
        orphan = 1'b0;
        wait_drain(100);

        // Randomized traffic with random back-pressure and engine pause.
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    push_req($urandom_range(0, 15), $urandom_range(0, 15));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    res_ready = ($urandom_range(0, 3) != 0);
                    eng_pause = ($urandom_range(0, 4) == 0);
                end
            end
        join
        res_ready = 1'b1;
        eng_pause = 1'b0;
        wait_drain(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
